// File: rtl/signed_seq_mult_pkg.sv
// Shared types and helpers for the signed/unsigned sequential shift-add multiplier.
// Optional early zero termination is enabled by defining SIGNED_SEQ_MULT_EARLY_ZERO_EN.
package signed_seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit counter width; it must hold values 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ssm_abs.sv
// Combinational conditional two's-complement negate: o_out = i_en ? -i_in : i_in.
// Used for operand magnitudes and for restoring the product sign.
module ssm_abs #(
    parameter int W = 8
) (
    input  logic         i_en,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    assign o_out = i_en ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/signed_seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, sign handled by magnitude/negate.
// Define SIGNED_SEQ_MULT_EARLY_ZERO_EN to skip straight to DONE when an operand is zero.
//
// Handshake: an operand set is taken on a rising edge where in_valid && in_ready; a product is
// handed off on a rising edge where out_valid && out_ready. in_ready is high only in IDLE and
// out_valid only in DONE, so the two never coincide. Counting the accept edge as edge 1,
// out_valid rises on edge WIDTH+2 (edge 1 with early zero termination).
module signed_seq_mult
    import signed_seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t            r_state;
    state_t            w_next;
    logic              w_calc_last;
    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_mcand;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     w_fixed;
    logic [PW-1:0]     r_p;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
`ifdef SIGNED_SEQ_MULT_EARLY_ZERO_EN
    logic              w_zero_op;

    assign w_zero_op = (a == '0) || (b == '0);
`endif

    // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned WIDTH-bit value.
    ssm_abs #(.W(WIDTH)) u_abs_a (
        .i_en  (signed_op & a[WIDTH-1]),
        .i_in  (a),
        .o_out (w_abs_a)
    );

    ssm_abs #(.W(WIDTH)) u_abs_b (
        .i_en  (signed_op & b[WIDTH-1]),
        .i_in  (b),
        .o_out (w_abs_b)
    );

    // Negating only a nonzero accumulator keeps zero results free of a negative zero.
    ssm_abs #(.W(PW)) u_sign_fix (
        .i_en  (r_neg & (r_acc != '0)),
        .i_in  (r_acc),
        .o_out (w_fixed)
    );

    assign w_calc_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
`ifdef SIGNED_SEQ_MULT_EARLY_ZERO_EN
                    w_next = w_zero_op ? DONE : CALC;
`else
                    w_next = CALC;
`endif
                end
            end
            CALC: begin
                if (w_calc_last) begin
                    w_next = SIGN;
                end
            end
            SIGN: begin
                w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The multiplicand is pre-shifted each cycle so no variable shifter is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_p      <= '0;
                    end
                end
                CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                SIGN: begin
                    r_p <= w_fixed;
                end
                default: begin
                end
            endcase
        end
    end

    assign p         = r_p;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_signed_seq_mult.sv
// Directed testbench for signed_seq_mult: 32-bit instance for the main vectors, 8-bit instance
// for the zero-operand latency case (expected latency follows SIGNED_SEQ_MULT_EARLY_ZERO_EN).
module tb_signed_seq_mult;

    localparam int W  = 32;
    localparam int W8 = 8;
`ifdef SIGNED_SEQ_MULT_EARLY_ZERO_EN
    localparam int ZLAT32 = 1;
    localparam int ZLAT8  = 1;
`else
    localparam int ZLAT32 = W + 2;
    localparam int ZLAT8  = W8 + 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit DUT
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            signed_op = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  p;
    logic            busy;
    logic [1:0]      dbg_state;

    // 8-bit DUT
    logic            in_valid8 = 1'b0;
    logic            in_ready8;
    logic [W8-1:0]   a8 = '0;
    logic [W8-1:0]   b8 = '0;
    logic            signed_op8 = 1'b0;
    logic            out_valid8;
    logic            out_ready8 = 1'b0;
    logic [2*W8-1:0] p8;
    logic            busy8;
    logic [1:0]      dbg_state8;

    signed_seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    signed_seq_mult #(.WIDTH(W8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .signed_op (signed_op8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8),
        .busy      (busy8),
        .dbg_state (dbg_state8)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sop,
                          input int hold, output logic [2*W-1:0] prod, output int lat);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        signed_op = sop;
        @(posedge clk);
        #1;
        lat       = 1;
        in_valid  = 1'b0;
        a         = $urandom_range(0, 32'hFFFF);
        b         = ~bv;
        signed_op = ~sop;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("op_timeout", {63'd0, out_valid}, 64'd1);
        prod = p;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_p", p, prod);
            check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
            check_eq("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("handoff_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("handoff_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic sop,
                           output logic [2*W8-1:0] prod, output int lat);
        in_valid8  = 1'b1;
        a8         = av;
        b8         = bv;
        signed_op8 = sop;
        @(posedge clk);
        #1;
        lat        = 1;
        in_valid8  = 1'b0;
        a8         = 8'h5A;
        b8         = 8'hA5;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("op8_timeout", {63'd0, out_valid8}, 64'd1);
        prod       = p8;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic vec32(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sop, input logic [63:0] expv, input int exp_lat);
        logic [2*W-1:0] prod;
        int lat;
        exp_q.push_back(expv);
        run_op(av, bv, sop, 0, prod, lat);
        check_eq({tag, "_p"}, prod, exp_q.pop_front());
        if (exp_lat > 0) check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic vec8(input string tag, input logic [W8-1:0] av, input logic [W8-1:0] bv,
                        input logic sop, input logic [15:0] expv, input int exp_lat);
        logic [2*W8-1:0] prod;
        int lat;
        exp_q.push_back({48'd0, expv});
        run_op8(av, bv, sop, prod, lat);
        check_eq({tag, "_p"}, {48'd0, prod}, exp_q.pop_front());
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    // ---------------- stimulus ----------------
    logic [2*W-1:0] hprod;
    int             hlat;
    logic           seen_valid;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_p", p, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vec32("neg3x5",    32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1, W + 2);
        vec32("min_sq",    32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, W + 2);
        vec32("min_x1",    32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, 0);
        vec32("u_ones_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, W + 2);
        vec32("s_ones_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0);
        vec32("s123xm456", 32'd123,       32'hFFFF_FE38, 1'b1, 64'hFFFF_FFFF_FFFF_24E8, 0);
        vec32("u_2p16_sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 0);
        vec32("zero_a",    32'd0,         32'd5,         1'b1, 64'd0, ZLAT32);
        vec32("zero_b_ng", 32'hFFFF_FFF9, 32'd0,         1'b1, 64'd0, ZLAT32);

        // Consumer stalls for 10 cycles.
        exp_q.push_back(64'd42);
        run_op(32'hFFFF_FFFA, 32'hFFFF_FFF9, 1'b1, 10, hprod, hlat);
        check_eq("stall_p", hprod, exp_q.pop_front());

        // Reset in the middle of CALC abandons the operation.
        in_valid  = 1'b1;
        a         = 32'd1000;
        b         = 32'd1000;
        signed_op = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("mid_busy", {63'd0, busy}, 64'd1);
        check_eq("mid_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("arst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("arst_p", p, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check_eq("no_valid_after_rst", {63'd0, seen_valid}, 64'd0);
        vec32("post_rst_7xm7", 32'd7, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFCF, W + 2);

        // 8-bit instance.
        vec8("w8_zero",   8'h00, 8'h85, 1'b1, 16'h0000, ZLAT8);
        vec8("w8_min_sq", 8'h80, 8'h80, 1'b1, 16'h4000, W8 + 2);
        vec8("w8_m123x3", 8'h85, 8'h03, 1'b1, 16'hFE8F, W8 + 2);
        vec8("w8_u_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, W8 + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
